// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle between the calc control stage and the shift-add multiplier.
// The control stage drives start/a/b through the master modport; the multiplier returns busy/done/product.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (output start, output a, output b, input busy, input done, input product);
    modport slave  (input start, input a, input b, output busy, output done, output product);
endinterface

// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier: WIDTH add/shift steps, then a registered product with a one-cycle done.
// Optional SIGNED_MULT_EN: two's complement operands via magnitude multiply and sign fix-up at DONE.
//
// state | meaning
// IDLE  | waiting for start (start ignored while the done pulse is out)
// RUN   | one conditional add + shift per cycle, count steps down to 1
// DONE  | product register and done pulse load on the edge leaving this state
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    shift_add_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic               accept;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] product_r;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [CW-1:0]      count;
    logic               done_r;

`ifdef SIGNED_MULT_EN
    logic neg;

    // Negating -2^(W-1) in W bits yields 2^(W-1), which is the correct unsigned magnitude.
    assign a_mag  = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
    assign b_mag  = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
    assign result = neg ? (~acc + 1'b1) : acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            neg <= 1'b0;
        end else if (accept) begin
            neg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        end
    end
`else
    assign a_mag  = bus.a;
    assign b_mag  = bus.b;
    assign result = acc;
`endif

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !done_r) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (count == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
            product_r <= '0;
            done_r    <= 1'b0;
        end else begin
            state  <= state_next;
            done_r <= (state == DONE);
            if (accept) begin
                mcand  <= {{WIDTH{1'b0}}, a_mag};
                mplier <= b_mag;
                acc    <= '0;
                count  <= CW'(WIDTH);
            end
            if (state == RUN) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count - CW'(1);
            end
            if (state == DONE) begin
                product_r <= result;
            end
        end
    end

    // busy spans the done pulse so the requester never sees an idle gap before the result.
    assign bus.busy    = (state != IDLE) || done_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
endmodule
